// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide unchanged.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the start edge
// CALC  | one multiply/divide bit per cycle, counter XLEN-1 down to 0
// DONE  | result registered, done pulse for one cycle
module rv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     mb_q, mb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, sa, sb, neg_in;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_zero, div_ovf;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_acc, prod_fix;
  logic [XLEN:0]       div_shift;
  logic                div_qbit;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   div_acc;
  logic [XLEN-1:0]     quo, fin_res;

  function automatic logic [XLEN-1:0] mul_pick(input logic [2:0] o,
                                                input logic [2*XLEN-1:0] p);
    return (o == 3'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // MUL is treated as signed; its low half is identical either way.
  always_comb begin
    a_signed = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sa       = a_signed && a[XLEN-1];
    sb       = b_signed && b[XLEN-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    if (op[2] && op[1]) neg_in = sa;
    else                neg_in = sa ^ sb;
    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    mul_acc   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_qbit  = (div_shift >= {1'b0, mb_q});
    div_rem   = div_qbit ? XLEN'(div_shift - {1'b0, mb_q}) : div_shift[XLEN-1:0];
    div_acc   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_qbit};
    prod_fix  = neg_q ? -mul_acc : mul_acc;
    quo       = div_acc[XLEN-1:0];
    case (op_q)
      3'd4, 3'd5: fin_res = neg_q ? -quo : quo;
      3'd6, 3'd7: fin_res = neg_q ? -div_rem : div_rem;
      default:    fin_res = mul_pick(op_q, prod_fix);
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  always_comb begin
    fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_prod = neg_in ? -fast_mag : fast_mag;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          neg_d = neg_in;
          mb_d  = mag_b;
          acc_d = {{XLEN{1'b0}}, mag_a};
          rem_d = '0;
          cnt_d = CW'(XLEN-1);
          if (div_zero) begin
            state_d  = DONE;
            result_d = op[1] ? a : '1;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = op[1] ? '0 : a;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!op[2]) begin
            state_d  = DONE;
            result_d = mul_pick(op, fast_prod);
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = op_q[2] ? div_acc : mul_acc;
          rem_d = op_q[2] ? div_rem : rem_q;
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = fin_res;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mb_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: directed vector table, hand-written
// cancel/reset sequences and randomized ops against an arithmetic reference model.
module tb_rv_muldiv_unit;

  localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic signed [63:0] xs, ys, p;
    logic               sx, sy;
    sx = (o == 3'd0) || (o == 3'd1) || (o == 3'd2);
    sy = (o == 3'd0) || (o == 3'd1);
    xs = sx ? {{32{x[31]}}, x} : {32'b0, x};
    ys = sy ? {{32{y[31]}}, y} : {32'b0, y};
    p  = xs * ys;
    case (o)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MINV && y == 32'hFFFF_FFFF) return x;
        return $signed(x) / $signed(y);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MINV && y == 32'hFFFF_FFFF) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o < 3'd4) return MUL_LAT;
    if (y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == MINV && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Launch one op, scramble operands after the start edge, wait for done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat, output int busy_gaps);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1; busy_gaps = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_gaps++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busy_gaps++;
    r = result;
    @(posedge clk); #1;
    if (done) busy_gaps++;
  endtask

  vec_t vecs[$];
  logic [31:0] r, prev;
  int lat, gaps, errs;

  initial begin
    vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd6, 32'h1234,      32'd0,         32'h1234,      1});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         MUL_LAT});

    rstn = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    #23;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk); rstn = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, gaps);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_profile", i), gaps, 32'd0);
    end

    // start during DONE must be ignored
    @(negedge clk);
    op = 3'd5; a = 32'd10; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    check("dz_done_cycle1", {31'b0, done}, 32'd1);
    op = 3'd5; a = 32'd99; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", {30'b0, busy, done}, 32'd0);

    // cancel sequence with re-start attempt while busy
    do_op(3'd5, 32'd1000, 32'd9, prev, lat, gaps);
    check("pre_cancel_result", prev, 32'd111);
    @(negedge clk);
    op = 3'd4; a = 32'd500; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; errs = 0;
    repeat (4) begin @(posedge clk); #1; if (done || !busy) errs++; end
    op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (done || !busy) errs++; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy_profile", errs, 32'd0);
    check("cancel_busy_low", {31'b0, busy}, 32'd0);
    check("cancel_no_done", {31'b0, done}, 32'd0);
    errs = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) errs++; end
    check("cancel_quiet_after", errs, 32'd0);
    check("cancel_result_kept", result, prev);
    do_op(3'd5, 32'd9, 32'd3, r, lat, gaps);
    check("after_cancel_divu", r, 32'd3);
    check("after_cancel_lat", lat, 32'd33);

    // cancel and start together in IDLE: start wins
    @(negedge clk);
    op = 3'd7; a = 32'd50; b = 32'd8; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start_beats_cancel", {31'b0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    check("start_beats_cancel_res", result, 32'd2);
    @(posedge clk); #1;

    // asynchronous reset mid-CALC
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_result", result, 32'd0);
    @(negedge clk); rstn = 1'b1;
    errs = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) errs++; end
    check("post_rst_quiet", errs, 32'd0);
    do_op(3'd0, 32'd3, 32'd5, r, lat, gaps);
    check("post_rst_mul", r, 32'd15);
    check("post_rst_mul_lat", lat, MUL_LAT);

    // randomized ops against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = MINV;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, r, lat, gaps);
      check($sformatf("rnd%0d_op%0d_a%h_b%h", n, ro, ra, rb), r, ref_result(ro, ra, rb));
      check($sformatf("rnd%0d_latency", n), lat, ref_lat(ro, ra, rb));
      check($sformatf("rnd%0d_busy_profile", n), gaps, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
